prpg_core_param: RTL

//  Parametrised pattern-generator core: WIDTH-bit Galois LFSR plus WIDTH-cell cyclic 3-neighbour CA.

---
 rtl/prpg_core_param.sv | 238 +++++++++++++++++++++++
 1 files changed

// File: rtl/prpg_core_param.sv
// Command-driven pattern generator: WIDTH-bit Galois LFSR, cyclic 3-neighbour CA and a local RAM.
// Define PRPG_HD_STATS_EN to enable per-LFSR-step Hamming-distance statistics (hd_last/hd_sum).
module prpg_core_param #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 256,
    parameter int unsigned HD_W  = 16,
    localparam int unsigned ADDR_W = $clog2(DEPTH),
    localparam int unsigned HDL_W  = $clog2(WIDTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [4:0]        cmd_op,
    input  logic [WIDTH-1:0]  cmd_arg,
    output logic [WIDTH-1:0]  lfsr_q,
    output logic [WIDTH-1:0]  ca_q,
    output logic [ADDR_W-1:0] r_addr,
    output logic [WIDTH-1:0]  rd_data,
    output logic              rd_valid,
    output logic              busy,
    output logic              done,
    output logic              halted,
    output logic [HDL_W-1:0]  hd_last,
    output logic [HD_W-1:0]   hd_sum
);

    localparam logic [4:0] OpCfgTap   = 5'h01;
    localparam logic [4:0] OpInitL    = 5'h02;
    localparam logic [4:0] OpRunL     = 5'h03;
    localparam logic [4:0] OpCfgC     = 5'h04;
    localparam logic [4:0] OpInitC    = 5'h05;
    localparam logic [4:0] OpRunC     = 5'h06;
    localparam logic [4:0] OpInitAddr = 5'h07;
    localparam logic [4:0] OpAddAddr  = 5'h08;
    localparam logic [4:0] OpStL      = 5'h09;
    localparam logic [4:0] OpLdL      = 5'h0A;
    localparam logic [4:0] OpStC      = 5'h0B;
    localparam logic [4:0] OpLdC      = 5'h0C;
    localparam logic [4:0] OpRd       = 5'h0D;
    localparam logic [4:0] OpBatchL   = 5'h0E;
    localparam logic [4:0] OpClrHd    = 5'h0F;
    localparam logic [4:0] OpHalt     = 5'h1F;

    localparam logic [ADDR_W:0] DepthW = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {StIdle, StRun, StHalt} state_e;
    typedef enum logic [1:0] {RunL, RunC, RunB} run_e;

    state_e state_q, state_d;
    run_e   run_q, run_d;

    logic [WIDTH-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:1]  tap_q, tap_d;  // tap[0] has no effect on the step
    logic [7:0]        rule_q, rule_d;
    logic [WIDTH-1:0]  lfsr_d, ca_d, rd_data_d;
    logic [ADDR_W-1:0] addr_d, addr_inc, addr_add, addr_init, arg_addr;
    logic [ADDR_W:0]   addr_sum;
    logic              rd_valid_d, done_d;
    logic              mem_we, lfsr_stepped, clr_hd;
    logic [WIDTH-1:0]  mem_wdata, mem_rd;
    logic [WIDTH-1:0]  lfsr_step, ca_step;
    logic              fb;

    logic [WIDTH-1:0] mem [DEPTH];

    assign cmd_ready = (state_q == StIdle);
    assign busy      = (state_q == StRun);
    assign halted    = (state_q == StHalt);
    assign mem_rd    = mem[r_addr];

    always_comb begin
        fb        = lfsr_q[WIDTH-1];
        lfsr_step = {lfsr_q[WIDTH-2:0], fb} ^ ({tap_q, 1'b0} & {WIDTH{fb}});
        for (int unsigned i = 0; i < WIDTH; i++) begin
            ca_step[i] = rule_q[{ca_q[(i + 1) % WIDTH], ca_q[i], ca_q[(i + WIDTH - 1) % WIDTH]}];
        end
        arg_addr  = ADDR_W'(cmd_arg);
        addr_sum  = {1'b0, r_addr} + {1'b0, arg_addr};
        addr_add  = ADDR_W'(addr_sum % DepthW);
        addr_init = ADDR_W'({1'b0, arg_addr} % DepthW);
        addr_inc  = (r_addr == ADDR_W'(DEPTH - 1)) ? '0 : r_addr + 1'b1;
    end

    always_comb begin
        state_d      = state_q;
        run_d        = run_q;
        cnt_d        = cnt_q;
        tap_d        = tap_q;
        rule_d       = rule_q;
        lfsr_d       = lfsr_q;
        ca_d         = ca_q;
        addr_d       = r_addr;
        rd_data_d    = rd_data;
        rd_valid_d   = 1'b0;
        done_d       = 1'b0;
        mem_we       = 1'b0;
        mem_wdata    = lfsr_q;
        lfsr_stepped = 1'b0;
        clr_hd       = 1'b0;
        case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    case (cmd_op)
                        OpCfgTap:   tap_d = cmd_arg[WIDTH-1:1];
                        OpInitL:    lfsr_d = cmd_arg;
                        OpRunL: if (cmd_arg != '0) begin
                            state_d = StRun;
                            cnt_d   = cmd_arg;
                            run_d   = RunL;
                        end
                        OpCfgC:     rule_d = 8'(cmd_arg);
                        OpInitC:    ca_d = cmd_arg;
                        OpRunC: if (cmd_arg != '0) begin
                            state_d = StRun;
                            cnt_d   = cmd_arg;
                            run_d   = RunC;
                        end
                        OpInitAddr: addr_d = addr_init;
                        OpAddAddr:  addr_d = addr_add;
                        OpStL:      mem_we = 1'b1;
                        OpLdL:      lfsr_d = mem_rd;
                        OpStC: begin
                            mem_we    = 1'b1;
                            mem_wdata = ca_q;
                        end
                        OpLdC:      ca_d = mem_rd;
                        OpRd: begin
                            rd_data_d  = mem_rd;
                            rd_valid_d = 1'b1;
                        end
                        OpBatchL: if (cmd_arg != '0) begin
                            state_d = StRun;
                            cnt_d   = cmd_arg;
                            run_d   = RunB;
                        end
                        OpClrHd:    clr_hd = 1'b1;
                        OpHalt:     state_d = StHalt;
                        default: ;
                    endcase
                end
            end
            StRun: begin
                cnt_d = cnt_q - WIDTH'(1);
                if (cnt_q == WIDTH'(1)) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
                case (run_q)
                    RunC: ca_d = ca_step;
                    RunB: begin
                        lfsr_d       = lfsr_step;
                        lfsr_stepped = 1'b1;
                        mem_we       = 1'b1;
                        mem_wdata    = lfsr_step;
                        addr_d       = addr_inc;
                    end
                    default: begin
                        lfsr_d       = lfsr_step;
                        lfsr_stepped = 1'b1;
                    end
                endcase
            end
            StHalt: ;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            run_q    <= RunL;
            cnt_q    <= '0;
            tap_q    <= '0;
            rule_q   <= '0;
            lfsr_q   <= '0;
            ca_q     <= '0;
            r_addr   <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
            done     <= 1'b0;
        end else begin
            state_q  <= state_d;
            run_q    <= run_d;
            cnt_q    <= cnt_d;
            tap_q    <= tap_d;
            rule_q   <= rule_d;
            lfsr_q   <= lfsr_d;
            ca_q     <= ca_d;
            r_addr   <= addr_d;
            rd_data  <= rd_data_d;
            rd_valid <= rd_valid_d;
            done     <= done_d;
        end
    end

    // RAM contents survive reset; only the write strobe is suppressed.
    always_ff @(posedge clk) begin
        if (mem_we && !rst) begin
            mem[r_addr] <= mem_wdata;
        end
    end

`ifdef PRPG_HD_STATS_EN
    function automatic logic [HDL_W-1:0] popcount(input logic [WIDTH-1:0] v);
        logic [HDL_W-1:0] n;
        n = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            n = n + HDL_W'(v[i]);
        end
        return n;
    endfunction

    logic [HDL_W-1:0] hd_step;
    logic [HD_W:0]    hd_acc;

    always_comb begin
        hd_step = popcount(lfsr_q ^ lfsr_step);
        hd_acc  = {1'b0, hd_sum} + (HD_W + 1)'(hd_step);
    end

    always_ff @(posedge clk) begin
        if (rst || clr_hd) begin
            hd_last <= '0;
            hd_sum  <= '0;
        end else if (lfsr_stepped) begin
            hd_last <= hd_step;
            hd_sum  <= hd_acc[HD_W] ? '1 : hd_acc[HD_W-1:0];
        end
    end
`else
    logic unused_hd;
    assign unused_hd = ^{clr_hd, lfsr_stepped};
    assign hd_last   = '0;
    assign hd_sum    = '0;
`endif

endmodule
